// File: rtl/gray_sync_rx.sv
// Gray-count receiver: synchronise a remote Gray count, convert to binary, report delta.
// Optional sticky illegal-transition flag enabled by defining GRAY_SYNC_ERR_CHECK_EN.
module gray_sync_rx #(
   parameter int DATA_WIDTH  = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] gray_in,
   output logic [DATA_WIDTH-1:0] binary_out,
   output logic                  changed,
   output logic [DATA_WIDTH-1:0] delta,
   output logic                  err,
   input  logic                  err_clr
);

   localparam logic [DATA_WIDTH-1:0] ZERO = {DATA_WIDTH{1'b0}};
   localparam logic [DATA_WIDTH-1:0] ONE  = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

   function automatic logic [DATA_WIDTH-1:0] gray2bin(input logic [DATA_WIDTH-1:0] g);
      logic [DATA_WIDTH-1:0] b;
      b = ZERO;
      b[DATA_WIDTH-1] = g[DATA_WIDTH-1];
      for (int i = DATA_WIDTH - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   // True when more than one bit of x is set (clearing the lowest set bit leaves something).
   function automatic logic multi_bit(input logic [DATA_WIDTH-1:0] x);
      return |(x & (x - ONE));
   endfunction

   logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] sync_r;
   logic [DATA_WIDTH-1:0]                  conv_s;

   // Synchroniser flop chain, plain register-to-register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_r[i] <= ZERO;
         end
      end else begin
         sync_r[0] <= gray_in;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_r[i] <= sync_r[i-1];
         end
      end
   end

   // Binary equivalent of the last synchroniser stage.
   always_comb begin
      conv_s = gray2bin(sync_r[SYNC_STAGES-1]);
   end

   // Output register: delta falls to zero naturally when nothing changed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         binary_out <= ZERO;
         changed    <= 1'b0;
         delta      <= ZERO;
      end else begin
         binary_out <= conv_s;
         changed    <= (conv_s != binary_out);
         delta      <= conv_s - binary_out;
      end
   end

`ifdef GRAY_SYNC_ERR_CHECK_EN
   logic [DATA_WIDTH-1:0] gray_q_r;
   logic                  illegal_s;

   // Hamming distance above one between consecutive last-stage samples.
   always_comb begin
      illegal_s = multi_bit(sync_r[SYNC_STAGES-1] ^ gray_q_r);
   end

   // Previous sample and sticky flag; a new violation outranks a clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gray_q_r <= ZERO;
         err      <= 1'b0;
      end else begin
         gray_q_r <= sync_r[SYNC_STAGES-1];
         if (illegal_s) begin
            err <= 1'b1;
         end else if (err_clr) begin
            err <= 1'b0;
         end else begin
            err <= err;
         end
      end
   end
`else
   logic unused_err_clr_s;

   assign unused_err_clr_s = err_clr;
   assign err              = 1'b0;
`endif

endmodule

// File: tb/tb_gray_sync_rx.sv
// Scoreboard bench for gray_sync_rx (DATA_WIDTH=4, SYNC_STAGES=2) with directed vectors.
module tb_gray_sync_rx;

   logic       clk;
   logic       rst_n;
   logic [3:0] gray_in;
   logic [3:0] binary_out;
   logic       changed;
   logic [3:0] delta;
   logic       err;
   logic       err_clr;

`ifdef GRAY_SYNC_ERR_CHECK_EN
   localparam logic ERR_EN = 1'b1;
`else
   localparam logic ERR_EN = 1'b0;
`endif

   typedef struct {
      logic [3:0] bin;
      logic [3:0] dlt;
      logic       e;
      int         cyc;
   } exp_t;

   exp_t q[$];
   int   cyc      = 0;
   int   chk_cnt  = 0;
   int   pass_cnt = 0;

   gray_sync_rx #(.DATA_WIDTH(4), .SYNC_STAGES(2)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .gray_in(gray_in),
      .binary_out(binary_out),
      .changed(changed),
      .delta(delta),
      .err(err),
      .err_clr(err_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      chk_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic push(input logic [3:0] b, input logic [3:0] d, input logic e, input int c);
      exp_t x;
      x.bin = b;
      x.dlt = d;
      x.e   = e;
      x.cyc = c;
      q.push_back(x);
   endtask

   // Monitor: every changed pulse must match the oldest expected update.
   always @(posedge clk) begin
      #1;
      while (q.size() > 0 && q[0].cyc < cyc) begin
         chk("sb_missed_update_cycle", cyc, q[0].cyc);
         void'(q.pop_front());
      end
      if (changed) begin
         if (q.size() == 0) begin
            chk("sb_unexpected_changed_bin", int'(binary_out), -1);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("sb_cycle", cyc, e.cyc);
            chk("sb_binary_out", int'(binary_out), int'(e.bin));
            chk("sb_delta", int'(delta), int'(e.dlt));
            chk("sb_err", int'(err), int'(e.e));
         end
      end else begin
         chk("idle_delta_zero", int'(delta), 0);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] b;
      rst_n   = 1'b1;
      gray_in = 4'd0;
      err_clr = 1'b0;
      #3 rst_n = 1'b0;
      #1;
      chk("rst_binary_out", int'(binary_out), 0);
      chk("rst_changed", int'(changed), 0);
      chk("rst_delta", int'(delta), 0);
      chk("rst_err", int'(err), 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("idle_binary_out", int'(binary_out), 0);
         chk("idle_err", int'(err), 0);
      end

      // Full Gray cycle back-to-back, including the 15 -> 0 wrap.
      for (int i = 1; i <= 16; i++) begin
         b = 4'(i);
         gray_in = b ^ (b >> 1);
         push(b, 4'd1, 1'b0, cyc + 3);
         @(negedge clk);
      end
      repeat (5) @(negedge clk);
      chk("wrap_binary_out", int'(binary_out), 0);
      chk("seq_err", int'(err), 0);

      // Illegal two-bit jump 0000 -> 0011.
      gray_in = 4'b0011;
      push(4'd2, 4'd2, ERR_EN, cyc + 3);
      repeat (5) @(negedge clk);
      chk("err_sticky", int'(err), int'(ERR_EN));
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      chk("err_cleared", int'(err), 0);
      chk("clr_keeps_binary", int'(binary_out), 2);

      // Another illegal jump 0011 -> 0101 arriving together with err_clr.
      gray_in = 4'b0101;
      push(4'd6, 4'd4, ERR_EN, cyc + 3);
      @(negedge clk);
      @(negedge clk);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      chk("err_set_wins", int'(err), int'(ERR_EN));
      repeat (3) @(negedge clk);

      gray_in = 4'b0100;
      push(4'd7, 4'd1, ERR_EN, cyc + 3);
      repeat (5) @(negedge clk);
      chk("pre_reset_binary", int'(binary_out), 7);

      // Reset with 1100 in flight; nothing of it may surface.
      gray_in = 4'b1100;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_binary_out", int'(binary_out), 0);
      chk("midrst_changed", int'(changed), 0);
      chk("midrst_delta", int'(delta), 0);
      chk("midrst_err", int'(err), 0);
      gray_in = 4'b0100;
      @(negedge clk);
      rst_n = 1'b1;
      push(4'd7, 4'd7, 1'b0, cyc + 3);
      repeat (6) @(negedge clk);
      chk("post_reset_binary", int'(binary_out), 7);
      chk("post_reset_err", int'(err), 0);
      chk("sb_drained", q.size(), 0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/gray_sync_rx.md
# gray_sync_rx

Receive-side stage that consumes a Gray-coded count produced in another clock domain, for example an async FIFO pointer from bin2gray. It synchronises the count into the local clock through a flop chain and converts it back to binary. It also reports the increment since the last update and, optionally, flags illegal multi-bit Gray transitions. All outputs are registered in the local domain.

## Interface
- DATA_WIDTH, 32, width of the Gray input and binary output (≥2)
- SYNC_STAGES, 2, synchroniser flop depth (≥2)

- clk  input  1  local clock; all state on rising edge
- rst_n  input  1  asynchronous, active-low reset; deassertion is synchronised externally
- gray_in  input  DATA_WIDTH  Gray-coded count from the remote domain; asynchronous to clk
- binary_out  output  DATA_WIDTH  registered binary equivalent of the synchronised Gray value
- changed  output  1  one-cycle pulse when binary_out takes a value different from its previous value
- delta  output  DATA_WIDTH  (new − old) mod 2^DATA_WIDTH for the current update; 0 when changed=0
- err  output  1  sticky illegal-transition flag (configurable)
- err_clr  input  1  synchronous clear for err

## Operation
- Synchroniser: gray_in → sync[0] → … → sync[SYNC_STAGES-1].
  - No logic between stages.
  - Every stage resets to 0.
- Gray→binary conversion is taken from sync[SYNC_STAGES-1], which is the last stage:
  - b[W-1] = g[W-1]
  - b[i] = b[i+1] ^ g[i] for i = W-2 … 0
- Output register updates every cycle:
  - binary_out ← converted value.
  - changed ← (converted ≠ binary_out).
  - delta ← converted − binary_out, truncated to DATA_WIDTH bits. Wrap from all-ones to 0 gives delta = 1.
- Previous-sample register gray_q holds the last-stage Gray value from the prior cycle and resets to 0.
- Transition check compares the last stage with gray_q:
  - Hamming distance 0 or 1 is legal.
  - Hamming distance >1 is illegal.
- err behaviour:
  - err is set the cycle after an illegal transition reaches the last stage, i.e. in the same cycle binary_out shows the jumped value.
  - err stays set until err_clr is sampled high.
  - If err_clr is high and a new illegal transition occurs in the same cycle, err = 1 (set wins).
- No handshake. The remote side guarantees that gray_in changes by at most one bit per local-clock period. The block tolerates any value without lock-up.

## Timing
- Reset (rst_n low) takes effect asynchronously. Outputs go immediately to:
  - binary_out = 0
  - changed = 0
  - delta = 0
  - err = 0
  - all sync stages and gray_q = 0
- Latency: a stable gray_in change sampled at edge N appears on binary_out, changed and delta after edge N+SYNC_STAGES. Total latency is SYNC_STAGES+1 edges counted from the capturing edge.
- changed is high for exactly one cycle per distinct value. If the value is constant, changed stays 0.
- Back-to-back changes on consecutive cycles give consecutive changed pulses, each with its own delta.
- Reset asserted mid-stream discards everything in flight. After release, the first update compares against 0.
- err_clr has no effect on binary_out, changed or delta.

## Configuration
- GRAY_SYNC_ERR_CHECK_EN defined:
  - gray_q, Hamming-distance detector and err flop are present.
  - Behaviour is as above.
- Not defined:
  - Detector logic is not instantiated.
  - err is tied to 0 and err_clr is ignored.
  - binary_out, changed and delta timing are unchanged.

## Test plan
Parameters for all cases: DATA_WIDTH=4, SYNC_STAGES=2.

- Reset release with gray_in held at 0000 → binary_out=0, changed=0, delta=0, err=0 for 20 cycles.
- gray_in 0000→0001 captured at edge N → at edge N+2: binary_out=1, changed=1 for one cycle, delta=1.
- Step gray_in through the full 16-value Gray sequence to 1000, then 0000 → binary_out 0,1,…,15,0. Every step has delta=1 and a changed pulse, including the wrap. err stays 0.
- Illegal jump gray_in 0000→0011 (macro defined) → binary_out=2, delta=2, err=1 and sticky.
  - err_clr pulse → err=0.
  - err_clr in the same cycle as another illegal jump → err stays 1.
  - Without the macro, err stays 0 throughout.
- rst_n pulsed low while binary_out=7 with a change in flight → all outputs are 0 asynchronously. After release with gray_in=0100 (binary 7): binary_out=7, changed=1, delta=7.
